rt_imp_hls_deadlock_report_ctrl: RTL
====================================

Name: rt_imp_hls_deadlock_report_ctrl

Overview:
- Central sequencer for the per-process deadlock detection units of an HLS dataflow region.
- Arbitrates among units raising a deadlock detect and elects one as origin.
- Broadcasts the global detect flag, circulates the report token and accumulates the process mask of the dependency cycle.
- Issues token_clear and presents one deadlock report per event on a valid/ready interface to the debug/status logic.

Parameters:
- PROC_NUM, 4, number of processes/detection units.
- TIMEOUT_CYC, 1024, max cycles to wait for the token to return (used only with DL_RPT_TIMEOUT_EN).
- ID_W, $clog2(PROC_NUM) (min 1), width of the process index.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dl_detect_vec  in  PROC_NUM  dl_detect_out of each unit.
- dep_data_vec  in  PROC_NUM*PROC_NUM  out_chan_dep_data of each unit, unit k at [k*PROC_NUM +: PROC_NUM].
- token_ret_vec  in  PROC_NUM  bit k = OR of unit k's token_in_vec.
- rearm  in  1  single-cycle pulse re-enabling detection after a report.
- dl_detect_in  out  1  global detect flag fanned out to all units.
- origin_vec  out  PROC_NUM  one-hot origin pulse.
- token_clear_vec  out  PROC_NUM  one-hot token clear pulse.
- rpt_valid  out  1  report valid.
- rpt_ready  in  1  report accept.
- rpt_proc_id  out  ID_W  elected origin process.
- rpt_dep_mask  out  PROC_NUM  accumulated cycle membership.
- rpt_timeout  out  1  report closed by timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = 0; latched id/mask/counter = 0. Asynchronous reset mid-operation aborts to IDLE in the same instant; a pending report is dropped.
- States: IDLE, ORIGIN, WAIT, REPORT, DONE. All outputs are registered except token_clear_vec.

IDLE:
- dl_detect_in = 0.
- If |dl_detect_vec, select a round-robin winner: the first set bit at index >= rr_ptr, wrapping modulo PROC_NUM.
- Latch id := winner and mask := dep_data_vec[id] | (1 << id); then rr_ptr := id+1 mod PROC_NUM, go to ORIGIN.
- Multiple simultaneous detects: only the winner is served; the others are ignored for this event.

ORIGIN (exactly 1 cycle):
- dl_detect_in = 1, origin_vec = 1 << id, counter := 0, go to WAIT.

WAIT:
- dl_detect_in = 1. Each cycle: mask |= dep_data_vec[k] for every k with token_ret_vec[k] = 1; counter increments.
- Closure condition: dl_detect_vec[id] & token_ret_vec[id].
- On closure, in the same cycle (combinational): token_clear_vec = 1 << id. Next state REPORT, rpt_timeout := 0.
- Closure and timeout in the same cycle: closure wins.

REPORT:
- rpt_valid = 1 with rpt_proc_id, rpt_dep_mask and rpt_timeout stable until rpt_ready.
- dl_detect_in stays 1, freezing unit dep registers.
- Handshake completes on the cycle rpt_valid & rpt_ready, then go to DONE.

DONE:
- dl_detect_in = 1, which suppresses repeat detections.
- On rearm: next cycle IDLE with dl_detect_in = 0.
- rearm is ignored in every other state.

Optional Feature:
DL_RPT_TIMEOUT_EN:
- Defined: a ceil(log2(TIMEOUT_CYC+1))-bit counter runs in WAIT. When counter == TIMEOUT_CYC-1 without closure, go to REPORT with rpt_timeout := 1; token_clear_vec is pulsed for the origin in that same cycle.
- Undefined: no counter is instantiated, WAIT exits only on closure, and rpt_timeout is tied to 0.

Decomposition:
- Shared package holds the state enum encoding (IDLE=0, ORIGIN=1, WAIT=2, REPORT=3, DONE=4), the ID_W derivation function and the report field widths.
- One sub-module: rt_imp_hls_rr_pick, a combinational round-robin priority picker (req vector, pointer → one-hot grant plus index), reusable by other arbiters.

Test Plan:
1. Single detect, PROC_NUM=4:
   - Stimulus: dl_detect_vec = 0100 in IDLE; dep_data_vec[2] = 0010; two cycles later token_ret_vec = 0011 with dep_data_vec[1] = 0001; then dl_detect_vec[2] & token_ret_vec[2].
   - Response: origin_vec = 0100 for one cycle; token_clear_vec = 0100 at closure; report id = 2, mask = 0111, timeout = 0.
2. Simultaneous detects:
   - Stimulus: dl_detect_vec = 1011 with rr_ptr = 0.
   - Response: id = 0. After rearm, the same stimulus gives id = 1; after the next rearm, id = 3 (pointer wrap).
3. Backpressure: rpt_ready held 0 for 10 cycles → rpt_valid and all fields stable, dl_detect_in = 1 throughout; accepted on the first ready cycle; DONE holds until rearm.
4. Timeout (macro defined, TIMEOUT_CYC = 16): no closure after ORIGIN → REPORT entered 16 cycles after WAIT entry with rpt_timeout = 1 and token_clear pulsed once. With the macro undefined, still in WAIT after 100 cycles.
5. Reset mid-WAIT: reset low → all outputs 0 immediately; after release, a new detect restarts from IDLE with rr_ptr = 0.
6. Stray inputs: rearm in WAIT, and token_ret_vec in IDLE → no state change and no outputs asserted.

Source files
------------

// File: rtl/rt_imp_hls_deadlock_report_ctrl_pkg.sv
// Shared types and width helpers for the HLS deadlock report controller and its arbiter.
// State encoding is fixed so debug logic can decode the state register directly.
package rt_imp_hls_deadlock_report_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ORIGIN = 3'd1,
        ST_WAIT   = 3'd2,
        ST_REPORT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Process index width; a single process still needs one bit.
    function automatic int id_width(input int proc_num);
        return (proc_num > 1) ? $clog2(proc_num) : 1;
    endfunction

    // Wait-counter width able to hold the value timeout_cyc.
    function automatic int cnt_width(input int timeout_cyc);
        return (timeout_cyc > 1) ? $clog2(timeout_cyc + 1) : 1;
    endfunction

    // Report field widths: id, dependency mask, timeout flag.
    function automatic int rpt_width(input int proc_num);
        return id_width(proc_num) + proc_num + 1;
    endfunction

    localparam int RPT_TIMEOUT_W = 1;

endpackage

// File: rtl/rt_imp_hls_rr_pick.sv
// Combinational round-robin priority picker: first request at index >= ptr, wrapping.
// Returns a one-hot grant, its index and an any-request flag.
module rt_imp_hls_rr_pick
    import rt_imp_hls_deadlock_report_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int k;

    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = IW'(k);
            end
        end
    end

endmodule

// File: rtl/rt_imp_hls_deadlock_report_ctrl.sv
// Central sequencer for per-process deadlock detection units: elects an origin, circulates
// the token, accumulates the cycle mask and reports it. Optional macro: DL_RPT_TIMEOUT_EN.
module rt_imp_hls_deadlock_report_ctrl
    import rt_imp_hls_deadlock_report_ctrl_pkg::*;
#(
    parameter int PROC_NUM    = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int ID_W        = id_width(PROC_NUM)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [PROC_NUM-1:0]          dl_detect_vec,
    input  logic [PROC_NUM*PROC_NUM-1:0] dep_data_vec,
    input  logic [PROC_NUM-1:0]          token_ret_vec,
    input  logic                         rearm,
    output logic                         dl_detect_in,
    output logic [PROC_NUM-1:0]          origin_vec,
    output logic [PROC_NUM-1:0]          token_clear_vec,
    output logic                         rpt_valid,
    input  logic                         rpt_ready,
    output logic [ID_W-1:0]              rpt_proc_id,
    output logic [PROC_NUM-1:0]          rpt_dep_mask,
    output logic                         rpt_timeout
);

    localparam logic [PROC_NUM-1:0] ONE = PROC_NUM'(1);

    state_t              state, state_n;
    logic [ID_W-1:0]     id_q, id_n;
    logic [ID_W-1:0]     rr_ptr, rr_n;
    logic [PROC_NUM-1:0] mask_q, mask_n;
    logic [PROC_NUM-1:0] ret_acc;
    logic                timeout_n;
    logic                closure;
    logic                expired;

    logic [PROC_NUM-1:0] win_grant;
    logic [ID_W-1:0]     win_idx;
    logic                win_any;

    rt_imp_hls_rr_pick #(
        .N  (PROC_NUM),
        .IW (ID_W)
    ) u_rr_pick (
        .req   (dl_detect_vec),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // Dependencies of every unit whose token came back this cycle.
    always_comb begin
        ret_acc = '0;
        for (int k = 0; k < PROC_NUM; k++) begin
            if (token_ret_vec[k]) ret_acc = ret_acc | dep_data_vec[k*PROC_NUM +: PROC_NUM];
        end
    end

    assign closure = dl_detect_vec[id_q] & token_ret_vec[id_q];

`ifdef DL_RPT_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                  cnt <= '0;
        else if (state == ST_ORIGIN) cnt <= '0;
        else if (state == ST_WAIT)   cnt <= cnt + 1'b1;
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_n         = state;
        id_n            = id_q;
        mask_n          = mask_q;
        rr_n            = rr_ptr;
        timeout_n       = 1'b0;
        token_clear_vec = '0;
        case (state)
            ST_IDLE: begin
                if (win_any) begin
                    id_n    = win_idx;
                    mask_n  = dep_data_vec[int'(win_idx)*PROC_NUM +: PROC_NUM] | win_grant;
                    rr_n    = (win_idx == ID_W'(PROC_NUM - 1)) ? '0 : win_idx + 1'b1;
                    state_n = ST_ORIGIN;
                end
            end
            ST_ORIGIN: state_n = ST_WAIT;
            ST_WAIT: begin
                mask_n = mask_q | ret_acc;
                // Closure has priority over an expiring counter.
                if (closure) begin
                    token_clear_vec = ONE << id_q;
                    state_n         = ST_REPORT;
                end else if (expired) begin
                    token_clear_vec = ONE << id_q;
                    timeout_n       = 1'b1;
                    state_n         = ST_REPORT;
                end
            end
            ST_REPORT: if (rpt_valid && rpt_ready) state_n = ST_DONE;
            ST_DONE:   if (rearm) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            id_q         <= '0;
            mask_q       <= '0;
            rr_ptr       <= '0;
            dl_detect_in <= 1'b0;
            origin_vec   <= '0;
            rpt_valid    <= 1'b0;
            rpt_proc_id  <= '0;
            rpt_dep_mask <= '0;
            rpt_timeout  <= 1'b0;
        end else begin
            state        <= state_n;
            id_q         <= id_n;
            mask_q       <= mask_n;
            rr_ptr       <= rr_n;
            dl_detect_in <= (state_n != ST_IDLE);
            origin_vec   <= (state_n == ST_ORIGIN) ? (ONE << id_n) : '0;
            rpt_valid    <= (state_n == ST_REPORT);
            if (state == ST_WAIT && state_n == ST_REPORT) begin
                rpt_proc_id  <= id_q;
                rpt_dep_mask <= mask_n;
                rpt_timeout  <= timeout_n;
            end else if (state == ST_REPORT && state_n == ST_DONE) begin
                rpt_proc_id  <= '0;
                rpt_dep_mask <= '0;
                rpt_timeout  <= 1'b0;
            end
        end
    end

endmodule
